// File: rtl/shift_ring_counter_if.sv
// Control and status bundle for shift_ring_counter: stepping/load controls in,
// counter state and event pulses out.
interface shift_ring_counter_if #(
    parameter int WIDTH = 16
);
    localparam int IW = $clog2(2*WIDTH);

    logic             en_i;
    logic             dir_i;
    logic             mode_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] cnt_o;
    logic [IW-1:0]    idx_o;
    logic             wrap_o;
    logic             load_err_o;

    modport master (
        output en_i, dir_i, mode_i, load_i, load_val_i,
        input  cnt_o, idx_o, wrap_o, load_err_o
    );

    modport slave (
        input  en_i, dir_i, mode_i, load_i, load_val_i,
        output cnt_o, idx_o, wrap_o, load_err_o
    );
endinterface

// File: rtl/shift_ring_counter.sv
// Shift-register sequence generator, run-time selectable between Johnson
// (period 2*WIDTH) and one-hot ring (period WIDTH), with checked parallel load.
module shift_ring_counter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    shift_ring_counter_if.slave  bus
);
    localparam int IW = $clog2(2*WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic [IW-1:0]    idx;
    logic [IW-1:0]    last_idx;
    logic [WIDTH-1:0] inv_val;
    logic             johnson_ok;
    logic             ring_ok;
    logic             load_legal;
    int               pop;
    int               pos;

    // A Johnson state is legal when it, or its complement, is 2^k-1.
    always_comb begin
        inv_val    = ~bus.load_val_i;
        johnson_ok = ((bus.load_val_i & (bus.load_val_i + ONE)) == '0) ||
                     ((inv_val & (inv_val + ONE)) == '0);
        ring_ok    = (bus.load_val_i != '0) &&
                     ((bus.load_val_i & (bus.load_val_i - ONE)) == '0);
        load_legal = (mode_q == MODE_RING) ? ring_ok : johnson_ok;
    end

    always_comb begin
        pop = $countones(cnt_q);
        pos = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q[i]) begin
                pos = i;
            end
        end
        if (mode_q == MODE_RING) begin
            idx      = IW'(pos);
            last_idx = IW'(WIDTH - 1);
        end else begin
            idx      = (cnt_q[0] || (cnt_q == '0)) ? IW'(pop) : IW'(2*WIDTH - pop);
            last_idx = IW'(2*WIDTH - 1);
        end
    end

    // Mode change re-initialises and masks everything else for that edge.
    always_comb begin
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (mode_e'(bus.mode_i) != mode_q) begin
            mode_d = mode_e'(bus.mode_i);
            cnt_d  = bus.mode_i ? ONE : '0;
        end else if (bus.load_i) begin
            if (load_legal) begin
                cnt_d = bus.load_val_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en_i) begin
            unique case ({mode_q == MODE_RING, bus.dir_i})
                2'b00: cnt_d = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
                2'b01: cnt_d = {~cnt_q[0], cnt_q[WIDTH-1:1]};
                2'b10: cnt_d = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
                default: cnt_d = {cnt_q[0], cnt_q[WIDTH-1:1]};
            endcase
            wrap_d = bus.dir_i ? (idx == '0) : (idx == last_idx);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q     <= MODE_JOHNSON;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.cnt_o      = cnt_q;
    assign bus.idx_o      = idx;
    assign bus.wrap_o     = wrap_q;
    assign bus.load_err_o = load_err_q;
endmodule
